// File: rtl/esm_dep_tracker.sv
// Register-dependency tracker: bs-slot instruction buffer with a per-register producer table,
// a bs x bs RAW matrix and lowest-index issue. Optional WAW ordering with ESM_WAW_TRACK_EN.
module esm_dep_tracker #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16,
  parameter int regnum                = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Instruction_word_size-1:0] in_instr,
  input  logic                             in_regwrite,
  input  logic                             in_alusrc,
  output logic [$clog2(bs)-1:0]            in_index,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [$clog2(bs)-1:0]            issue_index,
  output logic [Instruction_word_size-1:0] issue_instr,
  input  logic                             cmp_valid,
  input  logic [$clog2(bs)-1:0]            cmp_index,
  output logic [$clog2(bs):0]              occupancy
);
  localparam int IW = $clog2(bs);
  localparam int RB = $clog2(regnum);

  logic [bs-1:0]                                valid, issued, ready;
  logic [bs-1:0][bs-1:0]                        dep;
  logic [bs-1:0][Instruction_word_size-1:0]     mem;
  logic [regnum-1:0]                            prod_valid;
  logic [regnum-1:0][IW-1:0]                    prod_slot;
  logic [IW:0]                                  occ;
  logic [IW-1:0]                                free_idx, issue_idx;
  logic [RB-1:0]                                rd, rs1, rs2, rd_waw;
  logic [bs-1:0]                                new_dep, cmp_mask;
  logic                                         alloc, cmp_ok, iss;

  assign rd  = in_regwrite ? in_instr[7 +: RB] : '0;
  assign rs1 = in_instr[15 +: RB];
  assign rs2 = in_alusrc ? in_instr[20 +: RB] : '0;
`ifdef ESM_WAW_TRACK_EN
  assign rd_waw = rd;
`else
  assign rd_waw = '0;
`endif

  always_comb begin
    for (int i = 0; i < bs; i++)
      ready[i] = valid[i] && !issued[i] && (dep[i] == '0);
  end

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx  = IW'(i);
      if (ready[i])  issue_idx = IW'(i);
    end
  end

  assign in_ready    = ~&valid;
  assign in_index    = free_idx;
  assign issue_valid = |ready;
  assign issue_index = issue_idx;
  assign issue_instr = issue_valid ? mem[issue_idx] : '0;
  assign occupancy   = occ;

  assign alloc    = in_valid && in_ready;
  assign cmp_ok   = cmp_valid && valid[cmp_index] && issued[cmp_index];
  assign iss      = issue_valid && issue_ready;
  assign cmp_mask = cmp_ok ? (bs'(1) << cmp_index) : '0;

  // A producer retiring this very cycle must not leave a stale dependency behind.
  always_comb begin
    logic [RB-1:0] src;
    new_dep = '0;
    src     = '0;
    for (int k = 0; k < 3; k++) begin
      src = (k == 0) ? rs1 : (k == 1) ? rs2 : rd_waw;
      if (src != '0 && prod_valid[src] && !(cmp_ok && prod_slot[src] == cmp_index))
        new_dep = new_dep | (bs'(1) << prod_slot[src]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= '0;
      issued <= '0;
      dep    <= '0;
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (alloc && free_idx == IW'(i)) begin
          valid[i]  <= 1'b1;
          issued[i] <= 1'b0;
          dep[i]    <= new_dep;
        end else begin
          if (cmp_mask[i]) begin
            valid[i]  <= 1'b0;
            issued[i] <= 1'b0;
          end else if (iss && issue_idx == IW'(i)) begin
            issued[i] <= 1'b1;
          end
          dep[i] <= dep[i] & ~cmp_mask;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < bs; i++)
      if (alloc && free_idx == IW'(i)) mem[i] <= in_instr;
  end

  // Clear first, then let a same-cycle allocation reclaim the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_valid <= '0;
      prod_slot  <= '0;
    end else begin
      for (int r = 0; r < regnum; r++) begin
        if (cmp_ok && prod_slot[r] == cmp_index) prod_valid[r] <= 1'b0;
        if (alloc && rd != '0 && rd == RB'(r)) begin
          prod_valid[r] <= 1'b1;
          prod_slot[r]  <= free_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ <= '0;
    else if (alloc && !cmp_ok) occ <= occ + (IW+1)'(1);
    else if (!alloc && cmp_ok) occ <= occ - (IW+1)'(1);
  end
endmodule

// File: tb/tb_esm_dep_tracker.sv
// Directed bench for esm_dep_tracker: expected issue order is queued as stimulus is driven and
// popped on each issue handshake. Honours ESM_WAW_TRACK_EN like the design.
module tb_esm_dep_tracker;
  logic        clk, rst;
  logic        in_valid, in_ready, in_regwrite, in_alusrc;
  logic [31:0] in_instr, issue_instr;
  logic [3:0]  in_index, issue_index, cmp_index;
  logic        issue_valid, issue_ready, cmp_valid;
  logic [4:0]  occupancy;

  esm_dep_tracker #(.Instruction_word_size(32), .bs(16), .regnum(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc), .in_index(in_index),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_index(issue_index),
    .issue_instr(issue_instr), .cmp_valid(cmp_valid), .cmp_index(cmp_index),
    .occupancy(occupancy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] word; } exp_t;
  exp_t        q[$];
  logic [31:0] slot_word [16];
  logic [6:0]  wtag;
  int          n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    in_valid = 0; cmp_valid = 0; issue_ready = 0; in_regwrite = 0; in_alusrc = 0;
  endtask

  task automatic alloc(input string tag, input logic [4:0] rd, rs1, rs2,
                       input logic rw, as, input int exp_idx);
    logic [31:0] w;
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_idx"}, in_index, exp_idx);
    w = {wtag, rs2, rs1, 3'b000, rd, 7'h33};
    wtag++;
    slot_word[exp_idx] = w;
    in_instr = w; in_regwrite = rw; in_alusrc = as; in_valid = 1;
  endtask

  task automatic expect_issue(input int idx);
    exp_t e;
    e.idx = idx; e.word = slot_word[idx];
    q.push_back(e);
  endtask

  task automatic cmp(input int idx);
    cmp_valid = 1; cmp_index = 4'(idx);
  endtask

  task automatic do_issue(input string tag);
    exp_t e;
    int k = 0;
    while (!issue_valid && k < 20) begin tick(); k++; end
    if (!issue_valid) chk({tag, "_timeout"}, issue_valid, 1);
    else if (q.size() == 0) chk({tag, "_sb_empty"}, issue_valid, 0);
    else begin
      e = q.pop_front();
      chk({tag, "_iidx"}, issue_index, e.idx);
      chk({tag, "_iword"}, issue_instr, e.word);
      issue_ready = 1;
      tick();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; wtag = 7'd1;
    rst = 0; in_valid = 0; in_instr = '0; in_regwrite = 0; in_alusrc = 0;
    issue_ready = 0; cmp_valid = 0; cmp_index = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_index", in_index, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_index", issue_index, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_occ", occupancy, 0);
    rst = 1;
    tick();

    // basic: rd=3 rs1=1 rs2=2
    alloc("t1", 3, 1, 2, 1, 1, 0); tick();
    chk("t1_iv", issue_valid, 1);
    chk("t1_ii", issue_index, 0);
    chk("t1_occ", occupancy, 1);
    expect_issue(0); do_issue("t1");
    cmp(0); tick();
    chk("t1_occ0", occupancy, 0);

    // RAW through r3 resolved by completion
    alloc("t2a", 3, 0, 0, 1, 0, 0); tick();
    alloc("t2b", 0, 3, 0, 0, 0, 1); tick();
    expect_issue(0); do_issue("t2a");
    chk("t2_blocked", issue_valid, 0);
    cmp(0); tick();
    chk("t2_iv", issue_valid, 1);
    chk("t2_ii", issue_index, 1);
    expect_issue(1); do_issue("t2b");
    cmp(1); tick();
    chk("t2_occ", occupancy, 0);

    // consumer allocated while its producer completes
    alloc("t3a", 3, 0, 0, 1, 0, 0); tick();
    expect_issue(0); do_issue("t3a");
    alloc("t3b", 0, 3, 0, 0, 0, 1); cmp(0); tick();
    chk("t3_iv", issue_valid, 1);
    chk("t3_ii", issue_index, 1);
    chk("t3_occ", occupancy, 1);
    expect_issue(1); do_issue("t3b");
    cmp(1); tick();

    // new producer of r5 allocated while the old one completes: allocation wins
    alloc("t4a", 5, 0, 0, 1, 0, 0); tick();
    expect_issue(0); do_issue("t4a");
    alloc("t4b", 5, 0, 0, 1, 0, 1); cmp(0); tick();
    alloc("t4c", 0, 5, 0, 0, 0, 0); tick();
    expect_issue(1); do_issue("t4b");
    chk("t4_blocked", issue_valid, 0);
    cmp(1); tick();
    expect_issue(0); do_issue("t4c");
    cmp(0); tick();
    chk("t4_occ", occupancy, 0);

    // fill all slots, extra offer ignored, free slot 5
    for (int i = 0; i < 16; i++) begin
      alloc($sformatf("fill%0d", i), 0, 0, 0, 0, 0, i); tick();
    end
    chk("full_rdy", in_ready, 0);
    chk("full_occ", occupancy, 16);
    in_instr = 32'hdead_beef; in_valid = 1; tick();
    chk("full_occ2", occupancy, 16);
    for (int i = 0; i < 6; i++) begin expect_issue(i); do_issue($sformatf("fi%0d", i)); end
    cmp(5); tick();
    chk("free5_rdy", in_ready, 1);
    chk("free5_idx", in_index, 5);
    chk("free5_occ", occupancy, 15);
    for (int i = 0; i < 5; i++) begin cmp(i); tick(); end
    for (int i = 6; i < 16; i++) begin expect_issue(i); do_issue($sformatf("fi%0d", i)); end
    for (int i = 6; i < 16; i++) begin cmp(i); tick(); end
    chk("fill_occ0", occupancy, 0);

    // completions on unissued slots are ignored
    alloc("t5a", 7, 0, 0, 1, 0, 0); tick();
    alloc("t5b", 0, 7, 0, 0, 0, 1); tick();
    alloc("t5c", 0, 0, 0, 0, 0, 2); tick();
    cmp(0); tick();
    cmp(2); tick();
    chk("t5_occ", occupancy, 3);
    expect_issue(0); do_issue("t5a");
    expect_issue(2); do_issue("t5c");
    chk("t5_blocked", issue_valid, 0);
    cmp(0); tick();
    expect_issue(1); do_issue("t5b");
    cmp(1); tick(); cmp(2); tick();
    chk("t5_occ0", occupancy, 0);

    // WAW on r4
    alloc("t6a", 4, 0, 0, 1, 0, 0); tick();
    alloc("t6b", 4, 0, 0, 1, 0, 1); tick();
    expect_issue(0); do_issue("t6a");
`ifdef ESM_WAW_TRACK_EN
    chk("waw_blocked", issue_valid, 0);
    cmp(0); tick();
    expect_issue(1); do_issue("t6b");
    cmp(1); tick();
`else
    chk("waw_free_iv", issue_valid, 1);
    expect_issue(1); do_issue("t6b");
    cmp(0); tick(); cmp(1); tick();
`endif
    chk("t6_occ0", occupancy, 0);

    // asynchronous reset mid-operation
    alloc("t7a", 0, 0, 0, 0, 0, 0); tick();
    alloc("t7b", 0, 0, 0, 0, 0, 1); tick();
    #2 rst = 0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_iv", issue_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    @(negedge clk); rst = 1;
    alloc("t7c", 0, 0, 0, 0, 0, 0); tick();
    chk("t7_occ", occupancy, 1);
    expect_issue(0); do_issue("t7c");
    chk("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
